// File: rtl/i2s_stream_arbiter_pkg.sv
// Shared definitions for the I2S stream arbiter.
// Holds the FSM encoding and the default word/frame sizes.
package i2s_stream_arbiter_pkg;

    localparam int WORD_LENGTH_DEF = 16;
    localparam int FRAME_WORDS_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/i2s_stream_arbiter.sv
// Two-requester round-robin arbiter feeding the I2S transmit stream.
// Grants whole frames atomically through a single output register stage.
module i2s_stream_arbiter
    import i2s_stream_arbiter_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [WORD_LENGTH-1:0] s0_data,
    input  logic                   s0_valid,
    output logic                   s0_ready,
    input  logic [WORD_LENGTH-1:0] s1_data,
    input  logic                   s1_valid,
    output logic                   s1_ready,
    output logic [WORD_LENGTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [1:0]             grant,
    output logic                   frame_done
);

    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_WORDS - 1);

    arb_state_e             state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   m_valid_d;
    logic [WORD_LENGTH-1:0] m_data_d;
    logic                   load_ok;
    logic                   own_valid;
    logic                   own_xfer;
    logic [WORD_LENGTH-1:0] own_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b1;
            cnt_q   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
        end
    end

    assign load_ok   = !m_valid || m_ready;
    assign own_valid = owner_q ? s1_valid : s0_valid;
    assign own_data  = owner_q ? s1_data : s0_data;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant      = 2'b00;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        frame_done = 1'b0;
        own_xfer   = 1'b0;
        // Handshake outputs stay quiet during reset so nothing is consumed.
        if (rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable && (s0_valid || s1_valid)) begin
                        state_d = ST_GRANT;
                        owner_d = (s0_valid && s1_valid) ? !ptr_q : s1_valid;
                    end
                end
                ST_GRANT: begin
                    grant    = owner_q ? 2'b10 : 2'b01;
                    s0_ready = !owner_q && load_ok;
                    s1_ready = owner_q && load_ok;
                    own_xfer = own_valid && load_ok;
                    if (own_xfer) begin
                        if (cnt_q == LAST) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            ptr_d      = owner_q;
                            frame_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Load wins over drain, giving one word per cycle when both happen.
    always_comb begin
        m_valid_d = m_valid;
        m_data_d  = m_data;
        if (own_xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = own_data;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

endmodule
